// File: rtl/mtimer.sv
// mtimer: machine-mode timer peripheral.
//
// Holds a free-running 64-bit mtime counter advanced by a programmable
// prescaler, a 64-bit mtimecmp register and a CTRL register (EN, DIV).
// t_interrupt is a registered level that is high while the timer is
// enabled and mtime >= mtimecmp (unsigned, inclusive).
//
// Ports:
//   clk          single clock, all state on its rising edge
//   reset        synchronous, active-high
//   bus_sel      request valid, held until bus_ready
//   bus_wr       1 = write, 0 = read
//   bus_addr     byte address; [1:0] ignored
//   bus_wdata    write data
//   bus_rdata    registered read data, valid only with bus_ready, else 0
//   bus_ready    one-cycle completion pulse, one cycle after acceptance
//   t_interrupt  timer interrupt level
//
// Register map (bus_addr[4:2]):
//   0 MTIME_LO, 1 MTIME_HI (reads the snapshot taken by the last MTIME_LO
//   read), 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit 0 EN, DIV at bit 8).
//   Other addresses read 0 and ignore writes.
module mtimer #(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_sel,
  input  logic        bus_wr,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        t_interrupt
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;

  state_t                 state_reg;
  logic [63:0]            mtime_reg;
  logic [63:0]            mtimecmp_reg;
  logic                   en_reg;
  logic [PRESCALE_W-1:0]  div_reg;
  logic [PRESCALE_W-1:0]  pcnt_reg;
  logic [31:0]            hi_shadow_reg;

  logic                   accept;
  logic                   wr_en;
  logic                   rd_en;
  logic [2:0]             reg_idx;
  logic                   tick;
  logic [31:0]            ctrl_word;
  logic [31:0]            read_word;
  logic [63:0]            mtime_next;
  logic [PRESCALE_W-1:0]  pcnt_next;
  logic                   unused_addr_bits;

  // Byte offset within a word carries no meaning on this bus.
  assign unused_addr_bits = ^bus_addr[1:0];

  assign reg_idx = bus_addr[4:2];
  assign accept  = (state_reg == IDLE) && bus_sel;
  assign wr_en   = accept && bus_wr;
  assign rd_en   = accept && !bus_wr;
  assign tick    = en_reg && (pcnt_reg == div_reg);

  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[0]                = en_reg;
    ctrl_word[8 +: PRESCALE_W]  = div_reg;
  end

  always_comb begin
    read_word = '0;
    case (reg_idx)
      IDX_MTIME_LO: read_word = mtime_reg[31:0];
      IDX_MTIME_HI: read_word = hi_shadow_reg;
      IDX_CMP_LO:   read_word = mtimecmp_reg[31:0];
      IDX_CMP_HI:   read_word = mtimecmp_reg[63:32];
      IDX_CTRL:     read_word = ctrl_word;
      default:      read_word = '0;
    endcase
  end

  // A bus write to either mtime half overrides that cycle's tick; the
  // untouched half keeps its pre-tick value so no carry leaks into it.
  always_comb begin
    mtime_next = tick ? mtime_reg + 64'd1 : mtime_reg;
    if (wr_en && reg_idx == IDX_MTIME_LO) begin
      mtime_next = {mtime_reg[63:32], bus_wdata};
    end else if (wr_en && reg_idx == IDX_MTIME_HI) begin
      mtime_next = {bus_wdata, mtime_reg[31:0]};
    end
  end

  always_comb begin
    if (wr_en && reg_idx == IDX_CTRL) begin
      pcnt_next = '0;
    end else if (!en_reg || tick) begin
      pcnt_next = '0;
    end else begin
      pcnt_next = pcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mtime_reg     <= '0;
      mtimecmp_reg  <= CMP_RESET;
      en_reg        <= 1'b0;
      div_reg       <= '0;
      pcnt_reg      <= '0;
      hi_shadow_reg <= '0;
      bus_ready     <= 1'b0;
      bus_rdata     <= '0;
      t_interrupt   <= 1'b0;
    end else begin
      mtime_reg   <= mtime_next;
      pcnt_reg    <= pcnt_next;
      // Registered from the current state, so any change to mtime,
      // mtimecmp or EN shows up on t_interrupt one edge later.
      t_interrupt <= en_reg && (mtime_reg >= mtimecmp_reg);
      bus_ready   <= 1'b0;
      bus_rdata   <= '0;

      case (state_reg)
        IDLE: begin
          if (bus_sel) begin
            state_reg <= RESP;
            bus_ready <= 1'b1;
            if (!bus_wr) begin
              bus_rdata <= read_word;
            end
          end
        end
        RESP: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (wr_en) begin
        case (reg_idx)
          IDX_CMP_LO: mtimecmp_reg[31:0]  <= bus_wdata;
          IDX_CMP_HI: mtimecmp_reg[63:32] <= bus_wdata;
          IDX_CTRL: begin
            en_reg  <= bus_wdata[0];
            div_reg <= bus_wdata[8 +: PRESCALE_W];
          end
          default: ;
        endcase
      end

      // Snapshot the upper half so a LO-then-HI read pair is coherent.
      if (rd_en && reg_idx == IDX_MTIME_LO) begin
        hi_shadow_reg <= mtime_reg[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: self-checking bench for mtimer.
//
// A reference model updated once per clock edge tracks the register file,
// the bus handshake and the interrupt level. Ticks are derived from the
// number of edges since the last CTRL write (or reset) modulo DIV+1.
// Every cycle t_interrupt, bus_ready and bus_rdata are compared with the
// model; table vectors and directed sequences add constant expectations.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_sel;
  logic        bus_wr;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        t_interrupt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [63:0] m_mtime  = '0;
  logic [63:0] m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        m_en     = 1'b0;
  logic [7:0]  m_div    = '0;
  longint      m_age    = 0;
  logic [31:0] m_shadow = '0;
  logic        m_resp   = 1'b0;
  logic        m_ready  = 1'b0;
  logic [31:0] m_rdata  = '0;
  logic        m_tint   = 1'b0;

  mtimer #(.PRESCALE_W(8), .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_sel     (bus_sel),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .t_interrupt (t_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs sampled there.
  task automatic model_edge();
    logic        acc;
    logic [2:0]  idx;
    logic        tk;
    logic [63:0] nt;
    logic [31:0] rd;
    logic        ctrl_wr;
    if (reset) begin
      m_mtime = '0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 1'b0; m_div = '0;
      m_age = 0; m_shadow = '0; m_resp = 1'b0; m_ready = 1'b0; m_rdata = '0;
      m_tint = 1'b0;
    end else begin
      acc     = !m_resp && bus_sel;
      idx     = bus_addr[4:2];
      tk      = m_en && (((m_age + 1) % (longint'(m_div) + 1)) == 0);
      nt      = tk ? m_mtime + 64'd1 : m_mtime;
      rd      = '0;
      ctrl_wr = 1'b0;
      m_tint  = m_en && (m_mtime >= m_cmp);
      if (acc && !bus_wr) begin
        case (idx)
          3'd0: rd = m_mtime[31:0];
          3'd1: rd = m_shadow;
          3'd2: rd = m_cmp[31:0];
          3'd3: rd = m_cmp[63:32];
          3'd4: rd = {16'h0, m_div, 7'h0, m_en};
          default: rd = '0;
        endcase
        if (idx == 3'd0) m_shadow = m_mtime[63:32];
      end
      if (acc && bus_wr) begin
        case (idx)
          3'd0: nt = {m_mtime[63:32], bus_wdata};
          3'd1: nt = {bus_wdata, m_mtime[31:0]};
          3'd2: m_cmp[31:0]  = bus_wdata;
          3'd3: m_cmp[63:32] = bus_wdata;
          3'd4: begin
            m_en    = bus_wdata[0];
            m_div   = bus_wdata[15:8];
            ctrl_wr = 1'b1;
          end
          default: ;
        endcase
      end
      m_age   = ctrl_wr ? 0 : m_age + 1;
      m_mtime = nt;
      m_ready = acc;
      m_rdata = rd;
      m_resp  = acc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("t_interrupt", {63'h0, t_interrupt}, {63'h0, m_tint});
    chk("bus_ready", {63'h0, bus_ready}, {63'h0, m_ready});
    chk("bus_rdata", {32'h0, bus_rdata}, {32'h0, m_rdata});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic txn(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    bus_sel = 1'b1; bus_wr = wr; bus_addr = addr; bus_wdata = wd;
    step();
    rd = bus_rdata;
    chk("ready_at_k1", {63'h0, bus_ready}, 64'd1);
    bus_sel = 1'b0;
    step();
    $display("txn wr=%0d addr=%02h wdata=%08h rdata=%08h irq=%0d", wr, addr, wd, rd, t_interrupt);
  endtask

  task automatic wr32(input logic [4:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    txn(1'b1, addr, wd, dummy);
  endtask

  task automatic rd32(input logic [4:0] addr, output logic [31:0] rd);
    txn(1'b0, addr, 32'h0, rd);
  endtask

  task automatic check_reset_regs(input string tag);
    logic [31:0] exp_vals [5];
    logic [31:0] r;
    exp_vals[0] = 32'h0; exp_vals[1] = 32'h0;
    exp_vals[2] = 32'hFFFF_FFFF; exp_vals[3] = 32'hFFFF_FFFF; exp_vals[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      rd32(5'(i * 4), r);
      chk({tag, "_reg"}, {32'h0, r}, {32'h0, exp_vals[i]});
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] r;
    logic [31:0] r2;
    logic [31:0] wd;
    logic [2:0]  ridx;
    int          waited;

    tbl[0]  = '{1'b0, 5'h00, 32'h0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 5'h04, 32'h0, 32'h0000_0000};
    tbl[2]  = '{1'b0, 5'h08, 32'h0, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 5'h0C, 32'h0, 32'hFFFF_FFFF};
    tbl[4]  = '{1'b0, 5'h10, 32'h0, 32'h0000_0000};
    tbl[5]  = '{1'b1, 5'h08, 32'h0000_0123, 32'h0};
    tbl[6]  = '{1'b0, 5'h08, 32'h0, 32'h0000_0123};
    tbl[7]  = '{1'b0, 5'h0C, 32'h0, 32'hFFFF_FFFF};
    tbl[8]  = '{1'b1, 5'h14, 32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{1'b0, 5'h14, 32'h0, 32'h0000_0000};
    tbl[10] = '{1'b0, 5'h08, 32'h0, 32'h0000_0123};
    tbl[11] = '{1'b1, 5'h10, 32'hFFFF_2AFE, 32'h0};
    tbl[12] = '{1'b0, 5'h10, 32'h0, 32'h0000_2A00};
    tbl[13] = '{1'b1, 5'h00, 32'h0000_1234, 32'h0};
    tbl[14] = '{1'b0, 5'h00, 32'h0, 32'h0000_1234};
    tbl[15] = '{1'b0, 5'h04, 32'h0, 32'h0000_0000};
    tbl[16] = '{1'b0, 5'h13, 32'h0, 32'h0000_2A00};

    reset = 1'b1; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Reset values, plain register access, unmapped address, address LSBs.
    for (int i = 0; i < 17; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, r);
      if (!tbl[i].wr) chk($sformatf("table_%0d", i), {32'h0, r}, {32'h0, tbl[i].exp});
    end

    // Prescaler with DIV = 3; compare of 0 makes the interrupt immediate.
    wr32(5'h0C, 32'h0);
    wr32(5'h08, 32'h0);
    wr32(5'h10, 32'h0000_0301);
    chk("irq_after_en", {63'h0, t_interrupt}, 64'd1);
    rd32(5'h00, r);
    idle(6);
    rd32(5'h00, r2);
    chk("prescale_div3_ticks", {32'h0, r2 - r}, 64'd2);

    // Compare and clear.
    wr32(5'h10, 32'h0);
    wr32(5'h04, 32'h0);
    wr32(5'h00, 32'h0);
    wr32(5'h0C, 32'h0);
    wr32(5'h08, 32'd10);
    wr32(5'h10, 32'h0000_0001);
    waited = 0;
    while (t_interrupt !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    chk("irq_rise_in_time", {63'h0, waited < 100}, 64'd1);
    rd32(5'h00, r);
    chk("mtime_at_irq_rise", {32'h0, r}, 64'd11);
    wr32(5'h08, 32'd100);
    chk("irq_cleared", {63'h0, t_interrupt}, 64'd0);

    // Wrap at 2^64 with DIV = 0.
    wr32(5'h04, 32'hFFFF_FFFF);
    wr32(5'h00, 32'hFFFF_FFFE);
    rd32(5'h00, r);
    chk("wrap_lo_max", {32'h0, r}, 64'hFFFF_FFFF);
    rd32(5'h04, r);
    chk("wrap_hi_max", {32'h0, r}, 64'hFFFF_FFFF);
    rd32(5'h00, r);
    chk("wrap_lo_after", {32'h0, r}, 64'd3);
    rd32(5'h04, r);
    chk("wrap_hi_after", {32'h0, r}, 64'd0);

    // Snapshot across a carry out of the low word.
    wr32(5'h10, 32'h0);
    wr32(5'h04, 32'h0);
    wr32(5'h10, 32'h0000_0001);
    wr32(5'h00, 32'hFFFF_FFFE);
    rd32(5'h00, r);
    chk("snap_lo", {32'h0, r}, 64'hFFFF_FFFF);
    rd32(5'h04, r);
    chk("snap_hi_shadow", {32'h0, r}, 64'd0);
    rd32(5'h00, r);
    rd32(5'h04, r);
    chk("snap_hi_live", {32'h0, r}, 64'd1);

    // Write colliding with a tick (DIV = 0 ticks every edge).
    wr32(5'h00, 32'h55);
    rd32(5'h00, r);
    chk("collision_drop", {32'h0, r}, 64'h56);

    // Unmapped read latency and data.
    rd32(5'h14, r);
    chk("unmapped_read", {32'h0, r}, 64'd0);

    // Reset on the accepting edge: request is dropped.
    bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = 5'h08; bus_wdata = 32'h5;
    reset = 1'b1;
    step();
    reset = 1'b0; bus_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_ready_after_reset", {63'h0, bus_ready}, 64'd0);
    end
    check_reset_regs("reset_accept");

    // Reset while in RESP.
    wr32(5'h08, 32'd7);
    wr32(5'h10, 32'h0000_0001);
    bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = 5'h0C; bus_wdata = 32'h99;
    step();
    reset = 1'b1; bus_sel = 1'b0;
    step();
    chk("resp_reset_ready", {63'h0, bus_ready}, 64'd0);
    chk("resp_reset_irq", {63'h0, t_interrupt}, 64'd0);
    reset = 1'b0;
    idle(2);
    check_reset_regs("reset_resp");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      ridx = 3'($urandom_range(0, 7));
      if (ridx == 3'd4) begin
        wd       = $urandom;
        wd[15:8] = 8'($urandom_range(0, 3));
        wd[0]    = ($urandom_range(0, 3) != 0);
      end else if ($urandom_range(0, 7) == 0) begin
        wd = $urandom;
      end else begin
        wd = $urandom_range(0, 80);
      end
      txn(1'($urandom_range(0, 1)), {ridx, 2'($urandom_range(0, 3))}, wd, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
